// File: rtl/custom_fifo_core.sv
// 16-slot byte FIFO with packet checkpoint/rollback on both write and read pointers.
// fifo_full is measured against the read checkpoint so replayable bytes are never overwritten.
module custom_fifo_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              write_enable,
    input  logic              write_start,
    input  logic              write_error,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_enable,
    input  logic              read_start,
    input  logic              read_error,
    output logic [DATA_W-1:0] read_data,
    output logic              fifo_empty,
    output logic              fifo_full
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W-1:0] wchk;
    logic [ADDR_W-1:0] rchk;
    logic [ADDR_W-1:0] wptr_inc;
    logic [ADDR_W-1:0] rptr_inc;
    logic              do_write;
    logic              do_read;

    assign wptr_inc   = wptr + ADDR_W'(1);
    assign rptr_inc   = rptr + ADDR_W'(1);
    assign fifo_empty = (rptr == wptr);
    assign fifo_full  = (wptr_inc == rchk);

    assign do_write = write_enable && !fifo_full  && !write_error && !clear;
    assign do_read  = read_enable  && !fifo_empty && !read_error  && !clear;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr <= '0;
            wchk <= '0;
        end else if (clear) begin
            wptr <= '0;
            wchk <= '0;
        end else if (write_error) begin
            wptr <= wchk;
        end else begin
            if (write_start) begin
                wchk <= wptr;
            end
            if (do_write) begin
                wptr <= wptr_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rptr      <= '0;
            rchk      <= '0;
            read_data <= '0;
        end else if (clear) begin
            rptr <= '0;
            rchk <= '0;
        end else if (read_error) begin
            rptr <= rchk;
        end else begin
            if (read_start) begin
                rchk <= rptr;
            end
            if (do_read) begin
                read_data <= mem[rptr];
                rptr      <= rptr_inc;
            end
        end
    end

endmodule

// File: tb/tb_custom_fifo_core.sv
// Bench for custom_fifo_core: directed packet/rollback scenarios plus random traffic,
// checked every cycle against an array-and-index model of the FIFO.
module tb_custom_fifo_core;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       write_enable;
    logic       write_start;
    logic       write_error;
    logic [7:0] write_data;
    logic       read_enable;
    logic       read_start;
    logic       read_error;
    logic [7:0] read_data;
    logic       fifo_empty;
    logic       fifo_full;

    int n_cmp = 0;
    int n_bad = 0;

    custom_fifo_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .write_enable(write_enable),
        .write_start (write_start),
        .write_error (write_error),
        .write_data  (write_data),
        .read_enable (read_enable),
        .read_start  (read_start),
        .read_error  (read_error),
        .read_data   (read_data),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full)
    );

    always #5 tb_clk = ~tb_clk;

    // Reference model: byte array with indices kept as plain integers modulo 16.
    byte unsigned m_mem [16];
    int           m_w, m_r, m_wc, m_rc;
    byte unsigned m_rd;
    bit           m_full_now, m_empty_now;

    always @(posedge tb_clk or negedge n_rst) begin
        if (!n_rst) begin
            m_w = 0; m_r = 0; m_wc = 0; m_rc = 0; m_rd = 8'h00;
        end else if (clear) begin
            m_w = 0; m_r = 0; m_wc = 0; m_rc = 0;
        end else begin
            m_full_now  = (((m_w + 1) % 16) == m_rc);
            m_empty_now = (m_r == m_w);
            if (read_error) begin
                m_r = m_rc;
            end else begin
                if (read_start) m_rc = m_r;
                if (read_enable && !m_empty_now) begin
                    m_rd = m_mem[m_r];
                    m_r  = (m_r + 1) % 16;
                end
            end
            if (write_error) begin
                m_w = m_wc;
            end else begin
                if (write_start) m_wc = m_w;
                if (write_enable && !m_full_now) begin
                    m_mem[m_w] = write_data;
                    m_w        = (m_w + 1) % 16;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit cmp_on = 1'b0;

    always @(negedge tb_clk) begin
        if (cmp_on && n_rst) begin
            chk("model_empty", 32'(fifo_empty), 32'(m_r == m_w));
            chk("model_full",  32'(fifo_full),  32'(((m_w + 1) % 16) == m_rc));
            chk("model_rdata", 32'(read_data),  32'(m_rd));
        end
    end

    task automatic idle_inputs();
        clear = 0; write_enable = 0; write_start = 0; write_error = 0; write_data = 8'h00;
        read_enable = 0; read_start = 0; read_error = 0;
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #2;
        idle_inputs();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(posedge tb_clk);
        #2;
        n_rst = 1'b1;
    endtask

    task automatic wr(input logic [7:0] d, input bit st);
        write_enable = 1; write_start = st; write_data = d;
        tick();
    endtask

    task automatic rd(input bit st);
        read_enable = 1; read_start = st;
        tick();
    endtask

    initial begin
        idle_inputs();
        n_rst = 1'b0;
        #12;
        chk("reset_empty", 32'(fifo_empty), 32'd1);
        chk("reset_full",  32'(fifo_full),  32'd0);
        chk("reset_rdata", 32'(read_data),  32'h00);
        @(posedge tb_clk);
        #2;
        n_rst  = 1'b1;
        cmp_on = 1'b1;

        // Single byte round trip
        wr(8'hFF, 1);
        rd(1);
        chk("c1_rdata", 32'(read_data),  32'hFF);
        chk("c1_empty", 32'(fifo_empty), 32'd1);
        chk("c1_full",  32'(fifo_full),  32'd0);

        // Fill to capacity
        do_reset();
        for (int i = 0; i < 15; i++) begin
            wr(8'(i), i == 0);
            chk("c2_full",  32'(fifo_full),  (i == 14) ? 32'd1 : 32'd0);
            chk("c2_empty", 32'(fifo_empty), 32'd0);
        end
        wr(8'hEE, 0);
        chk("c2_write_when_full_empty", 32'(fifo_empty), 32'd0);

        // Drain in order
        for (int i = 0; i < 15; i++) begin
            rd(i == 0);
            chk("c3_rdata", 32'(read_data),  32'(i));
            chk("c3_empty", 32'(fifo_empty), (i == 14) ? 32'd1 : 32'd0);
        end
        rd(0);
        chk("c3_read_when_empty_hold", 32'(read_data), 32'd14);

        // Write rollback
        do_reset();
        for (int i = 0; i < 8; i++) wr(8'(i), i == 0);
        write_error = 1;
        tick();
        chk("c4_empty_after_werr", 32'(fifo_empty), 32'd1);
        for (int i = 8; i < 15; i++) wr(8'(i), 0);
        chk("c4_empty_after_refill", 32'(fifo_empty), 32'd0);
        for (int i = 8; i < 15; i++) begin
            rd(i == 8);
            chk("c4_rdata", 32'(read_data), 32'(i));
        end
        chk("c4_empty_drained", 32'(fifo_empty), 32'd1);

        // Read rollback / replay
        read_error = 1;
        tick();
        chk("c5_empty_after_rerr", 32'(fifo_empty), 32'd0);
        for (int i = 8; i < 15; i++) begin
            rd(i == 8);
            chk("c5_rdata", 32'(read_data), 32'(i));
        end
        chk("c5_empty_drained", 32'(fifo_empty), 32'd1);

        // Clear mid-packet
        for (int i = 0; i < 5; i++) wr(8'(8'h30 + i), i == 0);
        clear = 1;
        tick();
        chk("c6_clr_empty", 32'(fifo_empty), 32'd1);
        chk("c6_clr_full",  32'(fifo_full),  32'd0);
        chk("c6_clr_rdata_hold", 32'(read_data), 32'd14);
        wr(8'h5A, 1);
        rd(1);
        chk("c6_clr_newbyte", 32'(read_data), 32'h5A);

        // Asynchronous reset mid-packet
        for (int i = 0; i < 4; i++) wr(8'(8'h70 + i), i == 0);
        #1;
        n_rst = 1'b0;
        #1;
        chk("c6_arst_empty", 32'(fifo_empty), 32'd1);
        chk("c6_arst_full",  32'(fifo_full),  32'd0);
        chk("c6_arst_rdata", 32'(read_data),  32'h00);
        @(posedge tb_clk);
        #2;
        n_rst = 1'b1;
        wr(8'hA5, 1);
        rd(1);
        chk("c6_arst_newbyte", 32'(read_data), 32'hA5);

        // Random traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            write_enable = ($urandom_range(0, 99) < 60);
            write_data   = 8'($urandom);
            write_error  = ($urandom_range(0, 99) < 4);
            write_start  = !write_error && ($urandom_range(0, 99) < 10);
            read_enable  = ($urandom_range(0, 99) < 55);
            read_error   = ($urandom_range(0, 99) < 4);
            read_start   = !read_error && ($urandom_range(0, 99) < 10);
            clear        = ($urandom_range(0, 999) < 5);
            tick();
        end

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
